// File: rtl/cache_flush_pkg.sv
// rtl/cache_flush_pkg.sv - shared types for the cache flush sequencer
package cache_flush_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WRITEBACK,
        CLEAR,
        NEXT,
        DONE
    } statetype;

endpackage

// File: rtl/cache_flush_cnt.sv
// rtl/cache_flush_cnt.sv - set counter and one-hot way rotator for the flush walk
//
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   advance     step to the next way, or to way 0 of the next set after the last way
//   clear       return to set 0, way 0
//   FlushAdr    current set index
//   FlushWay    current way, one-hot
//   LastWay     FlushWay is the highest way
//   LastSet     FlushAdr is the highest set
module cache_flush_cnt #(
    parameter int NUMWAYS  = 4,
    parameter int NUMLINES = 128,
    parameter int SETLEN   = $clog2(NUMLINES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              clear,
    output logic [SETLEN-1:0]  FlushAdr,
    output logic [NUMWAYS-1:0] FlushWay,
    output logic              LastWay,
    output logic              LastSet
);

    localparam logic [NUMWAYS-1:0] WAY0 = NUMWAYS'(1);

    assign LastWay = FlushWay[NUMWAYS-1];
    assign LastSet = (FlushAdr == SETLEN'(NUMLINES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            FlushAdr <= '0;
            FlushWay <= WAY0;
        end else if (advance) begin
            if (LastWay) begin
                FlushWay <= WAY0;
                FlushAdr <= LastSet ? '0 : FlushAdr + SETLEN'(1);
            end else begin
                FlushWay <= {FlushWay[NUMWAYS-2:0], FlushWay[NUMWAYS-1]};
            end
        end
    end

endmodule

// File: rtl/cache_flush_ctrl.sv
// rtl/cache_flush_ctrl.sv - walks every set/way and writes back valid dirty lines on a flush request
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   FlushReq     level request to flush the whole cache
//   ValidWay     valid bits of set FlushAdr (arrives one cycle after FlushAdr)
//   DirtyWay     dirty bits of set FlushAdr (same timing as ValidWay)
//   WbAck        writeback of the current line accepted
//   FlushAdr     set index presented to the arrays
//   FlushWay     one-hot way under inspection
//   FlushActive  high outside IDLE; selects flush addressing in the arrays
//   WbReq        writeback request for (FlushAdr, FlushWay)
//   ClearDirty   one-cycle strobe clearing the dirty bit at (FlushAdr, FlushWay)
//   FlushDone    one-cycle completion pulse
module cache_flush_ctrl
    import cache_flush_pkg::*;
#(
    parameter int NUMWAYS  = 4,
    parameter int NUMLINES = 128,
    parameter int SETLEN   = $clog2(NUMLINES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FlushReq,
    input  logic [NUMWAYS-1:0] ValidWay,
    input  logic [NUMWAYS-1:0] DirtyWay,
    input  logic              WbAck,
    output logic [SETLEN-1:0]  FlushAdr,
    output logic [NUMWAYS-1:0] FlushWay,
    output logic              FlushActive,
    output logic              WbReq,
    output logic              ClearDirty,
    output logic              FlushDone
);

    statetype state, next_state;
    logic     advance, cnt_clear;
    logic     last_way, last_set;

    cache_flush_cnt #(
        .NUMWAYS (NUMWAYS),
        .NUMLINES(NUMLINES),
        .SETLEN  (SETLEN)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .clear   (cnt_clear),
        .FlushAdr(FlushAdr),
        .FlushWay(FlushWay),
        .LastWay (last_way),
        .LastSet (last_set)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        advance     = 1'b0;
        cnt_clear   = 1'b0;
        FlushActive = (state != IDLE);
        WbReq       = 1'b0;
        ClearDirty  = 1'b0;
        FlushDone   = 1'b0;
        case (state)
            IDLE: begin
                // Counter already sits at the origin here; holding it there is a no-op safeguard.
                cnt_clear = 1'b1;
                if (FlushReq) next_state = READ;
            end
            READ:  next_state = CHECK;
            // The set's valid/dirty word stays on the array outputs across all ways of the set,
            // so ways after the first go straight from NEXT back to CHECK.
            CHECK: next_state = |(FlushWay & ValidWay & DirtyWay) ? WRITEBACK : NEXT;
            WRITEBACK: begin
                WbReq = 1'b1;
                if (WbAck) next_state = CLEAR;
            end
            CLEAR: begin
                ClearDirty = 1'b1;
                next_state = NEXT;
            end
            NEXT: begin
                advance = 1'b1;
                if (!last_way)     next_state = CHECK;
                else if (!last_set) next_state = READ;
                else               next_state = DONE;
            end
            DONE: begin
                FlushDone  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// tb/tb_cache_flush_ctrl.sv - scoreboard testbench for cache_flush_ctrl
module tb_cache_flush_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       FlushReq = 1'b0;
    logic [3:0] ValidWay, DirtyWay;
    logic       WbAck;
    logic [1:0] FlushAdr;
    logic [3:0] FlushWay;
    logic       FlushActive, WbReq, ClearDirty, FlushDone;

    cache_flush_ctrl #(.NUMWAYS(4), .NUMLINES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .FlushReq   (FlushReq),
        .ValidWay   (ValidWay),
        .DirtyWay   (DirtyWay),
        .WbAck      (WbAck),
        .FlushAdr   (FlushAdr),
        .FlushWay   (FlushWay),
        .FlushActive(FlushActive),
        .WbReq      (WbReq),
        .ClearDirty (ClearDirty),
        .FlushDone  (FlushDone)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, t0 = 0, done_cnt = 0;

    logic [15:0] vinit = '0, dinit = '0, vmem = '0, dmem = '0;
    logic        load = 1'b0;
    int          ack_lat = 0, ack_cnt = 0;
    logic        ack_auto = 1'b0, ack_force = 1'b0;
    logic        mon_en = 1'b0;

    assign WbAck = ack_auto | ack_force;

    logic [5:0]  exp_pos[$];
    logic [5:0]  exp_wb[$];
    logic [13:0] exp_clr[$];
    int          exp_done[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event, value %0h, expected none", name, act);
    endtask

    // Tag/valid/dirty array model: registered read, dirty cleared on ClearDirty.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) begin
            vmem <= vinit;
            dmem <= dinit;
        end else if (ClearDirty) begin
            dmem[{FlushAdr, 2'b00} +: 4] <= dmem[{FlushAdr, 2'b00} +: 4] & ~FlushWay;
        end
        ValidWay <= vmem[{FlushAdr, 2'b00} +: 4];
        DirtyWay <= dmem[{FlushAdr, 2'b00} +: 4];
    end

    // Bus responder: acks on the ack_lat-th cycle of WbReq (0 = never).
    always @(negedge clk) begin
        if (WbReq) begin
            ack_cnt  = ack_cnt + 1;
            ack_auto = (ack_cnt == ack_lat);
        end else begin
            ack_cnt  = 0;
            ack_auto = 1'b0;
        end
    end

    // Monitor
    logic [5:0] prev_pos = 6'b00_0001;
    logic       prev_wb = 1'b0;
    int         run = 0, last_run = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if ({FlushAdr, FlushWay} != prev_pos) begin
                if (exp_pos.size() == 0) unexpected("pos", 32'({FlushAdr, FlushWay}));
                else check("pos", 32'({FlushAdr, FlushWay}), 32'(exp_pos.pop_front()));
                prev_pos = {FlushAdr, FlushWay};
            end
            if (WbReq) begin
                if (!prev_wb) begin
                    if (exp_wb.size() == 0) unexpected("wbreq", 32'({FlushAdr, FlushWay}));
                    else check("wbreq_line", 32'({FlushAdr, FlushWay}), 32'(exp_wb.pop_front()));
                end
                run++;
            end else if (prev_wb) begin
                last_run = run;
                run = 0;
            end
            prev_wb = WbReq;
            if (ClearDirty) begin
                if (exp_clr.size() == 0) unexpected("clear", 32'({FlushAdr, FlushWay}));
                else check("clear_len_line", 32'({last_run[7:0], FlushAdr, FlushWay}),
                           32'(exp_clr.pop_front()));
            end
            if (FlushDone) begin
                done_cnt++;
                if (exp_done.size() == 0) unexpected("done", 32'(cyc - t0));
                else check("done_cycle", 32'(cyc - t0), 32'(exp_done.pop_front()));
            end
        end
    end

    task automatic push_walk();
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 4; w++)
                if (w < 3) exp_pos.push_back({2'(s), 4'(1 << (w + 1))});
                else       exp_pos.push_back({2'((s + 1) % 4), 4'b0001});
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_pos_left"},   32'(exp_pos.size()),  32'd0);
        check({tag, "_wb_left"},    32'(exp_wb.size()),   32'd0);
        check({tag, "_clr_left"},   32'(exp_clr.size()),  32'd0);
        check({tag, "_done_left"},  32'(exp_done.size()), 32'd0);
        check({tag, "_idle"},       32'(FlushActive),     32'd0);
        exp_pos.delete(); exp_wb.delete(); exp_clr.delete(); exp_done.delete();
    endtask

    task automatic run_walk(input string tag, input logic [15:0] v, input logic [15:0] d,
                            input int lat, input int drop_at, input int nwalk, input int done1);
        int base, rel;
        @(negedge clk);
        vinit = v; dinit = d; load = 1'b1; ack_lat = lat;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < nwalk; k++) begin
            push_walk();
            exp_done.push_back(done1 + k * (done1 + 1));
        end
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 4; w++)
                if (v[s*4+w] && d[s*4+w]) begin
                    exp_wb.push_back({2'(s), 4'(1 << w)});
                    exp_clr.push_back({8'(lat), 2'(s), 4'(1 << w)});
                end
        base = done_cnt;
        FlushReq = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 200 && done_cnt < base + nwalk; i++) begin
            @(negedge clk);
            #1;
            rel = cyc - t0;
            if (rel == drop_at) FlushReq = 1'b0;
            if (nwalk > 1 && rel == done1 + 1)
                check({tag, "_gap_idle"}, 32'(FlushActive), 32'd0);
            if (nwalk > 1 && rel == done1 + 2) begin
                check({tag, "_restart_active"}, 32'(FlushActive), 32'd1);
                check({tag, "_restart_adr"},    32'(FlushAdr),    32'd0);
            end
            if (done_cnt >= base + nwalk) FlushReq = 1'b0;
        end
        FlushReq = 1'b0;
        check({tag, "_done_count"}, 32'(done_cnt - base), 32'(nwalk));
        repeat (3) @(negedge clk);
        #1;
        end_checks(tag);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_adr",    32'(FlushAdr),    32'd0);
        check("rst_way",    32'(FlushWay),    32'd1);
        check("rst_active", 32'(FlushActive), 32'd0);
        check("rst_wbreq",  32'(WbReq),       32'd0);
        check("rst_clear",  32'(ClearDirty),  32'd0);
        check("rst_done",   32'(FlushDone),   32'd0);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        run_walk("clean",    16'h0000, 16'h0000, 1, -1, 1, 37);
        run_walk("one",      16'h0408, 16'h0420, 3, -1, 1, 41);
        run_walk("invdirty", 16'h0000, 16'h00F0, 1, -1, 1, 37);
        run_walk("alldirty", 16'hFFFF, 16'hFFFF, 1, -1, 1, 69);
        run_walk("drop5",    16'h0000, 16'h0000, 1,  5, 1, 37);
        run_walk("hold",     16'h0000, 16'h0000, 1, -1, 2, 37);

        // Reset while waiting on a writeback at set 1, way 0.
        @(negedge clk);
        vinit = 16'h0010; dinit = 16'h0010; load = 1'b1; ack_lat = 0;
        @(negedge clk);
        load = 1'b0;
        exp_pos.push_back(6'b00_0010);
        exp_pos.push_back(6'b00_0100);
        exp_pos.push_back(6'b00_1000);
        exp_pos.push_back(6'b01_0001);
        exp_pos.push_back(6'b00_0001);
        exp_wb.push_back(6'b01_0001);
        FlushReq = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 60 && !WbReq; i++) begin
            @(negedge clk);
            #1;
        end
        check("rwb_reached", 32'(WbReq), 32'd1);
        check("rwb_cycle",   32'(cyc - t0), 32'd12);
        @(negedge clk);
        #1;
        reset = 1'b1;
        FlushReq = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        check("rwb_wbreq",  32'(WbReq),       32'd0);
        check("rwb_adr",    32'(FlushAdr),    32'd0);
        check("rwb_way",    32'(FlushWay),    32'd1);
        check("rwb_active", 32'(FlushActive), 32'd0);
        ack_force = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        ack_force = 1'b0;
        check("rwb_late_ack_active", 32'(FlushActive), 32'd0);
        check("rwb_late_ack_clear",  32'(ClearDirty),  32'd0);
        repeat (2) @(negedge clk);
        #1;
        end_checks("rwb");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
